axi_rd_arbiter: RTL and testbench

Shares one AXI4 read master port between NUM_REQ read requesters, such as the UART debug read bridge and a DMA or self-test engine.
- Round-robin arbitration on the AR channel.
- One burst outstanding at a time.
- R beats are steered back to the granted requester until the rlast handshake.
- Sits between the requesters and the interconnect slave port.

---
 rtl/axi_rd_arbiter_pkg.sv | 17 +
 rtl/axi_rd_arbiter_rr.sv | 54 +++++
 rtl/axi_rd_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the AXI read-channel arbiter.
package axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic logic [2:0] axsize_of(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr.sv
// Round-robin arbiter: first requester at or after rr_ptr wins; pointer moves past the winner on advance.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] cand;

    // Scan from the farthest slot back to rr_ptr so the closest requester is written last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((32'(rr_ptr_q) + 32'(k)) % NUM_REQ);
            if (req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_oh[i] = gnt_valid && (gnt_idx == IDX_W'(i));
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance && gnt_valid) begin
            rr_ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read master between NUM_REQ requesters, one burst in flight at a time.
// Optional sticky protocol checker built when AXI_RD_ARBITER_CHECK_EN is defined.
//   state | meaning
//   IDLE  | arbitrating; s_arready shown to the round-robin winner
//   ADDR  | presenting latched AR to the master until m_arready
//   DATA  | steering R beats to the granted requester until rlast
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_araddr,
    input  logic [NUM_REQ*8-1:0]          s_arlen,
    input  logic [NUM_REQ-1:0]            s_arvalid,
    output logic [NUM_REQ-1:0]            s_arready,
    output logic [DATA_WIDTH-1:0]         s_rdata,
    output logic [1:0]                    s_rresp,
    output logic                          s_rlast,
    output logic [NUM_REQ-1:0]            s_rvalid,
    input  logic [NUM_REQ-1:0]            s_rready,
    output logic [ID_WIDTH-1:0]           m_arid,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [7:0]                    m_arlen,
    output logic [2:0]                    m_arsize,
    output logic [1:0]                    m_arburst,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [ID_WIDTH-1:0]           m_rid,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    output logic                          err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [7:0]            beat_q, beat_d;
    logic                  arvalid_q, arvalid_d;

    logic [NUM_REQ-1:0]    arb_req, gnt_oh;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_valid;
    logic                  in_data, r_hs;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [7:0]            sel_len;

    // Requests are only visible to the arbiter while idle, so s_arready is zero in ADDR/DATA and reset.
    assign arb_req = (state_q == IDLE && rst_n) ? s_arvalid : '0;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (arb_req),
        .advance   (gnt_valid),
        .gnt_oh    (gnt_oh),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign s_arready = gnt_oh;

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                sel_addr = s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = s_arlen[i*8 +: 8];
            end
        end
    end

    assign in_data  = (state_q == DATA);
    assign m_rready = in_data && s_rready[grant_q];
    assign r_hs     = m_rvalid && m_rready;

    always_comb begin
        s_rvalid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            s_rvalid[i] = in_data && m_rvalid && (grant_q == IDX_W'(i));
        end
    end

    assign s_rdata   = m_rdata;
    assign s_rresp   = m_rresp;
    assign s_rlast   = m_rlast;

    assign m_arid    = ID_WIDTH'(grant_q);
    assign m_araddr  = araddr_q;
    assign m_arlen   = arlen_q;
    assign m_arvalid = arvalid_q;
    assign m_arsize  = axsize_of(DATA_WIDTH);
    assign m_arburst = AXI_BURST_INCR;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        beat_d    = beat_q;
        arvalid_d = arvalid_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    grant_d   = gnt_idx;
                    araddr_d  = sel_addr;
                    arlen_d   = sel_len;
                    arvalid_d = 1'b1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    beat_d    = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (r_hs) begin
                    beat_d = beat_q + 8'd1;
                    if (m_rlast) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            beat_q    <= '0;
            arvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            beat_q    <= beat_d;
            arvalid_q <= arvalid_d;
        end
    end

`ifdef AXI_RD_ARBITER_CHECK_EN
    logic err_q, err_d, beat_bad;

    // Routing still follows m_rlast; the checker only flags, it never alters the burst.
    always_comb begin
        beat_bad = (m_rid != ID_WIDTH'(grant_q))
                || (m_rlast && (beat_q != arlen_q))
                || (!m_rlast && (beat_q == arlen_q));
        err_d    = err_q || (r_hs && beat_bad);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_chk;
    assign unused_chk = ^{m_rid, beat_q};
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized scoreboard bench for axi_rd_arbiter with a queue-based reference model.
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::AXI_RESP_OKAY;

    localparam int NREQ = 3;
    localparam int DW   = 64;
    localparam int AW   = 32;
    localparam int IW   = 4;
`ifdef AXI_RD_ARBITER_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ*AW-1:0]   s_araddr;
    logic [NREQ*8-1:0]    s_arlen;
    logic [NREQ-1:0]      s_arvalid, s_arready, s_rvalid, s_rready;
    logic [DW-1:0]        s_rdata, m_rdata;
    logic [1:0]           s_rresp, m_rresp, m_arburst;
    logic                 s_rlast, m_rlast, m_arvalid, m_arready, m_rvalid, m_rready, err;
    logic [IW-1:0]        m_arid, m_rid;
    logic [AW-1:0]        m_araddr;
    logic [7:0]           m_arlen;
    logic [2:0]           m_arsize;

    axi_rd_arbiter #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; } req_t;
    typedef struct packed { logic [IW-1:0] g; logic [AW-1:0] addr; logic [7:0] len; } ar_t;
    typedef struct packed { logic [DW-1:0] data; logic last; logic bad; } beat_t;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input int k);
        return {a ^ 32'h5A5A_0000, 32'(k) * 32'h0101_0101 + 32'h0000_1234};
    endfunction

    // Stimulus and model state
    req_t  pend_q[NREQ][$];
    ar_t   exp_ar[$];
    beat_t exp_r[$];
    int    grant_log[$];
    int    m_phase = 0;   // 0 idle, 1 address, 2 data
    int    m_ptr = 0;
    int    cur_g = 0;
    int    beats_cur = 0;
    int    addr_cycles = 0;
    logic  err_exp = 1'b0;
    bit    inject_next = 0, inject_armed = 0;
    logic [NREQ-1:0] hs_ar_v = '0;
    bit    hs_mar = 0, hs_mr = 0;
    int    rready_pct = 100, rvalid_pct = 100, ar_delay = 0, stall_cnt = 0;

    // Slave-side responder state
    bit            slv_active = 0;
    logic [AW-1:0] slv_addr = '0;
    logic [IW-1:0] slv_id = '0;
    int            slv_last = 0, slv_beat = 0, ar_cnt = 0;

    // Monitor variables
    int              mon_g, mon_last;
    logic [NREQ-1:0] mon_rdy, mon_rv;
    req_t            mon_r;
    beat_t           mon_e;

    initial begin
        rst_n = 1'b0;
        s_araddr = '0; s_arlen = '0; s_arvalid = '0; s_rready = '0;
        m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                for (int i = 0; i < NREQ; i++) pend_q[i].delete();
                s_arvalid = '0; m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
                slv_active = 0; ar_cnt = 0;
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (hs_ar_v[i] && pend_q[i].size() > 0) void'(pend_q[i].pop_front());
                    s_arvalid[i] = (pend_q[i].size() > 0);
                    if (pend_q[i].size() > 0) begin
                        s_araddr[i*AW +: AW] = pend_q[i][0].addr;
                        s_arlen[i*8 +: 8]    = pend_q[i][0].len;
                    end
                    s_rready[i] = (stall_cnt > 0) ? 1'b0 : ($urandom_range(0, 99) < rready_pct);
                end
                if (stall_cnt > 0) stall_cnt--;
                if (hs_mr) begin
                    m_rvalid = 1'b0;
                    if (slv_beat == slv_last) slv_active = 0;
                    else slv_beat++;
                end
                if (hs_mar) begin
                    slv_active = 1; slv_addr = m_araddr; slv_id = m_arid;
                    slv_last = inject_armed ? 1 : int'(m_arlen);
                    inject_armed = 0; slv_beat = 0; m_arready = 1'b0; ar_cnt = 0;
                end else if (!slv_active && m_arvalid) begin
                    m_arready = (ar_cnt >= ar_delay);
                    ar_cnt++;
                end else begin
                    m_arready = 1'b0;
                end
                if (slv_active && !m_rvalid) m_rvalid = ($urandom_range(0, 99) < rvalid_pct);
                m_rdata = pat(slv_addr, slv_beat);
                m_rlast = slv_active && (slv_beat == slv_last);
                m_rid   = slv_id;
                m_rresp = 2'b00;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_outputs", {s_arready, s_rvalid, m_rready, m_arvalid, m_araddr, m_arlen, m_arid, err}, '0);
                m_phase = 0; m_ptr = 0; err_exp = 1'b0; inject_armed = 0;
                hs_ar_v = '0; hs_mar = 0; hs_mr = 0;
                exp_ar.delete(); exp_r.delete();
            end else begin
                mon_g = -1;
                if (m_phase == 0) begin
                    for (int k = 0; k < NREQ; k++) begin
                        if (mon_g < 0 && s_arvalid[(m_ptr + k) % NREQ]) mon_g = (m_ptr + k) % NREQ;
                    end
                end
                mon_rdy = (mon_g >= 0) ? NREQ'(1 << mon_g) : '0;
                chk("s_arready", s_arready, mon_rdy);
                if (m_phase == 1) begin
                    chk("m_arvalid_held", m_arvalid, 1'b1);
                    chk("m_ar_fields", {m_arid, m_araddr, m_arlen, m_arsize, m_arburst},
                        {exp_ar[0].g, exp_ar[0].addr, exp_ar[0].len, 3'd3, 2'b01});
                end else begin
                    chk("m_arvalid_low", m_arvalid, 1'b0);
                end
                mon_rv = (m_phase == 2 && m_rvalid) ? NREQ'(1 << cur_g) : '0;
                chk("s_rvalid", s_rvalid, mon_rv);
                chk("m_rready", m_rready, (m_phase == 2) ? s_rready[cur_g] : 1'b0);
                chk("err", err, err_exp);
                hs_ar_v = s_arvalid & s_arready;
                hs_mar  = m_arvalid && m_arready;
                hs_mr   = m_rvalid && m_rready;
                case (m_phase)
                    0: if (mon_g >= 0 && pend_q[mon_g].size() > 0) begin
                        mon_r = pend_q[mon_g][0];
                        exp_ar.push_back('{g: IW'(mon_g), addr: mon_r.addr, len: mon_r.len});
                        mon_last = inject_next ? 1 : int'(mon_r.len);
                        for (int k = 0; k <= mon_last; k++)
                            exp_r.push_back('{data: pat(mon_r.addr, k), last: (k == mon_last), bad: inject_next && (k == mon_last)});
                        inject_armed = inject_next; inject_next = 0;
                        cur_g = mon_g; m_ptr = (mon_g + 1) % NREQ;
                        grant_log.push_back(mon_g);
                        beats_cur = 0; addr_cycles = 0; m_phase = 1;
                    end
                    1: begin
                        addr_cycles++;
                        if (m_arready) begin
                            void'(exp_ar.pop_front());
                            m_phase = 2;
                        end
                    end
                    default: if (m_rvalid && s_rready[cur_g]) begin
                        chk("r_queue_nonempty", exp_r.size() > 0, 1'b1);
                        if (exp_r.size() > 0) begin
                            mon_e = exp_r.pop_front();
                            chk("r_beat", {s_rdata, s_rlast, s_rresp}, {mon_e.data, mon_e.last, AXI_RESP_OKAY});
                            beats_cur++;
`ifdef AXI_RD_ARBITER_CHECK_EN
                            if (mon_e.bad) err_exp = 1'b1;
`endif
                            if (mon_e.last) m_phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    task automatic push_req(input int r, input logic [AW-1:0] a, input logic [7:0] l);
        pend_q[r].push_back('{addr: a, len: l});
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int c;
        bit done;
        c = 0; done = 0;
        while (!done && c < budget) begin
            @(posedge clk); #3; c++;
            done = (m_phase == 0) && (exp_r.size() == 0);
            for (int i = 0; i < NREQ; i++) if (pend_q[i].size() > 0) done = 0;
        end
        chk({nm, "_completed"}, done, 1'b1);
    endtask

    task automatic wait_beats(input int n, input string nm);
        int c;
        c = 0;
        while (!(m_phase == 2 && beats_cur >= n) && c < 500) begin
            @(posedge clk); #3; c++;
        end
        chk({nm, "_reached"}, (m_phase == 2 && beats_cur >= n), 1'b1);
    endtask

    initial begin
        logic [15:0] order;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Two requesters contending from reset: expect 0,1,0,1
        @(posedge clk); #3;
        grant_log.delete();
        push_req(0, 32'h0000_1000, 8'd0); push_req(0, 32'h0000_2000, 8'd0);
        push_req(1, 32'h0000_3000, 8'd0); push_req(1, 32'h0000_4000, 8'd0);
        wait_idle(300, "contention");
        order = (grant_log.size() == 4) ?
                {4'(grant_log[0]), 4'(grant_log[1]), 4'(grant_log[2]), 4'(grant_log[3])} : 16'hFFFF;
        chk("grant_order", order, 16'h0101);

        // Single requester, 4-beat burst
        push_req(0, 32'h1000_0040, 8'd3);
        wait_idle(300, "single");
        chk("single_beats", beats_cur, 4);

        // AR backpressure for 10 cycles while requester 1 waits
        ar_delay = 10;
        push_req(0, 32'h2000_0000, 8'd1); push_req(1, 32'h2100_0000, 8'd1);
        wait_idle(400, "backpressure");
        chk("ar_wait_cycles", addr_cycles, 11);
        ar_delay = 0;

        // R stall by the granted requester mid-burst
        push_req(2, 32'h3000_0100, 8'd7);
        wait_beats(3, "stall_point");
        stall_cnt = 5;
        wait_idle(300, "stall");
        chk("stall_beats", beats_cur, 8);

        // Reset after 2 of 8 beats, then rr_ptr must be back at 0
        push_req(0, 32'h4000_0000, 8'd7);
        wait_beats(2, "reset_point");
        rst_n = 1'b0;
        #1 chk("reset_immediate", {s_arready, s_rvalid, m_rready, m_arvalid, m_araddr, m_arlen, m_arid, err}, '0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #3;
        grant_log.delete();
        push_req(1, 32'h4100_0000, 8'd1); push_req(0, 32'h4200_0000, 8'd1);
        wait_idle(300, "post_reset");
        chk("post_reset_first_grant", (grant_log.size() == 2) ? grant_log[0] : -1, 0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #3;
            rready_pct = $urandom_range(40, 100);
            rvalid_pct = $urandom_range(30, 100);
            ar_delay   = $urandom_range(0, 3);
            push_req($urandom_range(0, NREQ - 1), $urandom & 32'hFFFF_FFF8, 8'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 12)) @(posedge clk);
        end
        wait_idle(4000, "random");
        rready_pct = 100; rvalid_pct = 100; ar_delay = 0;

        // Early rlast on a 4-beat burst; err depends on the checker build
        @(posedge clk); #3;
        inject_next = 1;
        push_req(0, 32'h5000_0000, 8'd3);
        wait_idle(300, "bad_burst");
        repeat (3) @(posedge clk);
        #3 chk("err_after_bad", err, EXP_ERR);
        push_req(1, 32'h5100_0000, 8'd2);
        wait_idle(300, "after_bad");
        chk("err_sticky", err, EXP_ERR);
        rst_n = 1'b0;
        #1 chk("err_cleared_by_reset", err, 1'b0);
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        n_fail++;
        $display("FAIL watchdog: got cycle limit expected test end");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
